fanin_feeder: RTL and testbench
===============================

FANIN_FEEDER -- requirements
Module: fanin_feeder

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 0: 0 = first serial bit lands on a, last on h; 1 = first bit lands on h, last on a.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of frame_count.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port sin, input, 1 bit: serial data bit, qualified by sin_valid.
REQ-006 The block SHALL have port sin_valid, input, 1 bit: sin carries a bit this cycle.
REQ-007 The block SHALL have port sin_start, input, 1 bit: the current valid bit is bit 0 of a new frame; ignored when sin_valid=0.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the downstream 8-to-1 fan-in consumer accepts the presented frame.
REQ-009 The block SHALL have ports a, b, c, d, e, f, g, h, each output, 1 bit: registered parallel frame bits that directly drive the fan-in tree's inputs of the same names.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a..h hold a complete frame.
REQ-011 The block SHALL have port frame_abort, output, 1 bit: one-cycle pulse when a partial frame is discarded.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky flag set when input bits are dropped.
REQ-013 The block SHALL have port frame_count, output, CNT_W bits: count of accepted frames.

Function
REQ-014 The block SHALL implement three states: IDLE, SHIFT, HOLD; the bit index is a 3-bit counter idx; frame bits collect in an internal 8-bit shift register, separate from a..h.
REQ-015 In IDLE, sin_valid=1 with sin_start=1 SHALL capture sin as bit 0, set idx=1 and go to SHIFT; sin_valid=1 with sin_start=0 SHALL be ignored with no flag.
REQ-016 In SHIFT, sin_valid=1 with sin_start=0 SHALL capture sin at position idx and increment idx; cycles with sin_valid=0 SHALL hold all state, with no timeout.
REQ-017 In SHIFT, the capture at idx=7 SHALL load all 8 bits into a..h simultaneously on that same edge, set out_valid=1, set idx=0 and go to HOLD; latency is 1 cycle from the 8th valid bit to out_valid.
REQ-018 In SHIFT, sin_valid=1 with sin_start=1 SHALL discard the partial frame, pulse frame_abort=1 for exactly one cycle, capture sin as the new bit 0 and set idx=1.
REQ-019 Bit mapping SHALL be: with MSB_FIRST=0, bit k drives output k (a=0 … h=7); with MSB_FIRST=1, bit k drives output 7-k.
REQ-020 In HOLD, a..h and out_valid=1 SHALL remain stable until out_ready=1.
REQ-021 A handshake is out_valid=1 and out_ready=1 on the same edge; on a handshake the block SHALL clear out_valid, increment frame_count modulo 2^CNT_W (255 wraps to 0 for CNT_W=8) and go to IDLE.
REQ-022 A handshake coinciding with sin_valid=1 and sin_start=1 SHALL go directly to SHIFT, capturing that bit as bit 0 with idx=1, giving zero bubble cycles.
REQ-023 In HOLD without a handshake, any sin_valid=1 bit SHALL be dropped and overrun set to 1; overrun SHALL stay 1 until rst.
REQ-024 After a handshake, a..h SHALL retain the last frame values and SHALL change only on the next frame load.
REQ-025 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-026 While rst=1, asynchronously and independent of clk, the block SHALL force state=IDLE, idx=0, shift register=0, a..h=0, out_valid=0, frame_abort=0, overrun=0 and frame_count=0.
REQ-027 Reset asserted mid-frame or in HOLD SHALL discard all data; after release, the first accepted bit SHALL be one with sin_start=1.

Verification
REQ-028 The bench SHALL cover: MSB_FIRST=0, serial bits 1,0,1,1,0,0,1,0 (start on first), out_ready=1 -> a..h=1,0,1,1,0,0,1,0; out_valid high 1 cycle after the 8th bit; frame_count=1.
REQ-029 The bench SHALL cover: same stream with MSB_FIRST=1 -> h..a=1,0,1,1,0,0,1,0.
REQ-030 The bench SHALL cover: start plus 3 bits, then a new start -> frame_abort pulses once; the next 8 bits form the frame; out_valid never rises early.
REQ-031 The bench SHALL cover: frame held with out_ready=0 for 5 cycles while 2 valid bits arrive -> a..h unchanged; overrun=1 persists after the handshake.
REQ-032 The bench SHALL cover: back-to-back frames with the handshake on the same cycle as the next sin_start -> no bubble; frame_count increments by 2 over the two frames; 256 frames wrap frame_count to 0.
REQ-033 The bench SHALL cover: rst pulsed between clock edges at idx=5 -> all outputs read 0 immediately; bits without sin_start after release are ignored.

Source files
------------

// File: rtl/fanin_feeder.sv
// Deserialises 8-bit serial frames onto the a..h inputs of a downstream 8-to-1 fan-in tree.
// Latency: a..h and out_valid update on the same edge that captures the 8th valid bit (1 cycle).
// Backpressure: a frame is held until out_ready; serial bits arriving meanwhile are dropped and overrun sets.
module fanin_feeder #(
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  input  logic             out_ready,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  output logic             f,
  output logic             g,
  output logic             h,
  output logic             out_valid,
  output logic             frame_abort,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] idx;
  logic [7:0] sreg;
  logic [7:0] out_word;   // bit 0 drives a, bit 7 drives h
  logic [7:0] frame;
  logic [7:0] load_word;

  assign a = out_word[0];
  assign b = out_word[1];
  assign c = out_word[2];
  assign d = out_word[3];
  assign e = out_word[4];
  assign f = out_word[5];
  assign g = out_word[6];
  assign h = out_word[7];

  // Complete frame as it would look with the current bit merged in, mapped onto a..h order.
  always_comb begin
    frame      = sreg;
    frame[idx] = sin;
    load_word  = '0;
    for (int i = 0; i < 8; i++) begin
      load_word[i] = (MSB_FIRST != 0) ? frame[7-i] : frame[i];
    end
  end

  // Frame assembly, output hold and handshake control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 3'd0;
      sreg        <= 8'd0;
      out_word    <= 8'd0;
      out_valid   <= 1'b0;
      frame_abort <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          // Only a start bit opens a frame; stray bits are silently ignored.
          if (sin_valid && sin_start) begin
            sreg  <= {7'd0, sin};
            idx   <= 3'd1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (sin_valid) begin
            if (sin_start) begin
              // A new start mid-frame restarts assembly from this bit.
              frame_abort <= 1'b1;
              sreg        <= {7'd0, sin};
              idx         <= 3'd1;
            end else if (idx == 3'd7) begin
              sreg      <= frame;
              out_word  <= load_word;
              out_valid <= 1'b1;
              idx       <= 3'd0;
              state     <= HOLD;
            end else begin
              sreg[idx] <= sin;
              idx       <= idx + 3'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            frame_count <= frame_count + {{(CNT_W-1){1'b0}}, 1'b1};
            // A start bit on the handshake edge begins the next frame with no bubble.
            if (sin_valid && sin_start) begin
              sreg  <= {7'd0, sin};
              idx   <= 3'd1;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end else if (sin_valid) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fanin_feeder.sv
// Scoreboarded bench: two instances (LSB-first and MSB-first) share one serial stream.
// Stimulus pushes each expected frame word (bit k = k-th serial bit) into a queue;
// a negedge monitor pops and compares whenever out_valid rises.
module tb_fanin_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sin_start = 1'b0;
  logic       out_ready = 1'b0;

  logic       a0, b0, c0, d0, e0, f0, g0, h0, vld0, abt0, ovr0;
  logic [7:0] cnt0;
  logic       a1, b1, c1, d1, e1, f1, g1, h1, vld1, abt1, ovr1;
  logic [7:0] cnt1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic       prev_vld = 1'b0;

  always #5 clk = ~clk;

  fanin_feeder #(.MSB_FIRST(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
    .out_ready(out_ready),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0), .h(h0),
    .out_valid(vld0), .frame_abort(abt0), .overrun(ovr0), .frame_count(cnt0)
  );

  fanin_feeder #(.MSB_FIRST(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
    .out_ready(out_ready),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1),
    .out_valid(vld1), .frame_abort(abt1), .overrun(ovr1), .frame_count(cnt1)
  );

  // LSB-first instance read as {h..a}; MSB-first instance read as {a..h}: both equal the frame word.
  function automatic logic [7:0] word0();
    return {h0, g0, f0, e0, d0, c0, b0, a0};
  endfunction

  function automatic logic [7:0] word1();
    return {a1, b1, c1, d1, e1, f1, g1, h1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input logic st);
    sin       = v;
    sin_start = st;
    sin_valid = 1'b1;
    tick();
  endtask

  // Sends one full frame; checks abort on the first bit and that out_valid lands exactly on the 8th.
  task automatic send_frame(input logic [7:0] w, input logic exp_abort);
    exp_q.push_back(w);
    for (int k = 0; k < 8; k++) begin
      drive_bit(w[k], k == 0);
      if (k == 0) check("abort_on_start", {31'd0, abt0}, {31'd0, exp_abort});
      if (k == 1) check("abort_one_cycle", {31'd0, abt0}, 32'd0);
      if (k == 6) check("valid_not_early", {31'd0, vld0}, 32'd0);
      if (k == 7) check("valid_latency", {31'd0, vld0}, 32'd1);
    end
    sin_valid = 1'b0;
    sin_start = 1'b0;
  endtask

  // Scoreboard monitor: every new frame presentation must match the oldest expected word.
  always @(negedge clk) begin
    if (vld0 && !prev_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame: got 0x%0h expected none", word0());
      end else begin
        logic [7:0] w;
        w = exp_q.pop_front();
        check("frame_lsb_first", {24'd0, word0()}, {24'd0, w});
        check("frame_msb_first", {24'd0, word1()}, {24'd0, w});
      end
    end
    prev_vld = vld0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;

    // Reset state
    #12;
    check("rst_word0", {24'd0, word0()}, 32'd0);
    check("rst_word1", {24'd0, word1()}, 32'd0);
    check("rst_valid", {29'd0, vld0, vld1, ovr0}, 32'd0);
    check("rst_count", {24'd0, cnt0}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic frame 1,0,1,1,0,0,1,0 with ready high
    out_ready = 1'b1;
    send_frame(8'h4D, 1'b0);
    check("basic_a_to_h", {24'd0, a0, b0, c0, d0, e0, f0, g0, h0}, 32'hB2);
    check("basic_h_to_a_msb", {24'd0, h1, g1, f1, e1, d1, c1, b1, a1}, 32'hB2);
    tick();
    check("basic_valid_cleared", {31'd0, vld0}, 32'd0);
    check("basic_count", {24'd0, cnt0}, 32'd1);
    check("basic_outputs_retained", {24'd0, word0()}, 32'h4D);

    // Partial frame aborted by a new start
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    check("partial_no_valid", {31'd0, vld0}, 32'd0);
    send_frame(8'hA5, 1'b1);
    tick();
    check("abort_count", {24'd0, cnt0}, 32'd2);

    // Hold with backpressure while stray bits arrive
    check("no_overrun_yet", {31'd0, ovr0}, 32'd0);
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    held = word0();
    for (int i = 0; i < 5; i++) begin
      sin       = 1'b1;
      sin_start = 1'b0;
      sin_valid = (i == 1 || i == 3);
      tick();
      check("hold_valid", {31'd0, vld0}, 32'd1);
      check("hold_stable", {24'd0, word0()}, {24'd0, held});
    end
    sin_valid = 1'b0;
    check("overrun_set", {31'd0, ovr1}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("hold_handshake_count", {24'd0, cnt0}, 32'd3);
    check("overrun_sticky", {31'd0, ovr0}, 32'd1);
    check("hold_retained", {24'd0, word0()}, 32'h3C);
    tick();
    tick();
    check("ready_idle_no_effect", {24'd0, cnt0}, 32'd3);

    // Back-to-back: handshake on the same edge as the next start bit
    out_ready = 1'b0;
    send_frame(8'h81, 1'b0);
    out_ready = 1'b1;
    send_frame(8'h7E, 1'b0);
    tick();
    check("b2b_count_plus2", {24'd0, cnt0}, 32'd5);

    // Asynchronous reset between edges at idx=5
    out_ready = 1'b0;
    drive_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    sin_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("arst_word0", {24'd0, word0()}, 32'd0);
    check("arst_word1", {24'd0, word1()}, 32'd0);
    check("arst_flags", {28'd0, vld0, abt0, ovr0, ovr1}, 32'd0);
    check("arst_count", {24'd0, cnt0}, 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) drive_bit(1'b1, 1'b0);
    sin_valid = 1'b0;
    tick();
    check("post_rst_ignore", {31'd0, vld0}, 32'd0);
    out_ready = 1'b1;
    send_frame(8'hC3, 1'b0);
    tick();
    check("post_rst_count", {24'd0, cnt0}, 32'd1);

    // 255 more back-to-back frames: count reaches 255 then wraps to 0
    for (int n = 0; n < 255; n++) begin
      logic [7:0] fv;
      fv = n[7:0] ^ 8'h5A;
      send_frame(fv, 1'b0);
    end
    check("count_255", {24'd0, cnt0}, 32'd255);
    tick();
    check("count_wrap", {24'd0, cnt0}, 32'd0);
    check("count_wrap_msb", {24'd0, cnt1}, 32'd0);

    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
